// File: rtl/dds_phase_gen.sv
// ============================================================================
// dds_phase_gen
// ----------------------------------------------------------------------------
// Direct digital synthesis phase generator. A phase accumulator advances by
// step_act every enabled cycle; its top ADDR_W bits address an external sine
// ROM and also drive locally generated square, triangle and sawtooth shapes.
// Frequency (step_val) and waveform (wave_sel) are shadowed every cycle but
// only take effect at a period boundary (accumulator carry) or while idle,
// so a running waveform never glitches mid-period.
//
// Pipeline (3 cycles from an accumulator value to wave_out):
//    stage 1 : rom_addr / sel / valid registered from acc
//    stage 2 : address, sel and valid delayed to line up with rom_data
//    stage 3 : waveform select into wave_out
//
// Ports
//    clk       in   system clock, rising edge
//    rst_n     in   asynchronous active-low reset
//    en        in   accumulate enable (low freezes the accumulator)
//    step_val  in   phase increment, ACC_W bits
//    wave_sel  in   00 sine, 01 square, 10 triangle, 11 sawtooth
//    rom_addr  out  registered sine ROM address (ROM has 1-cycle latency)
//    rom_data  in   offset-binary sine sample for the previous rom_addr
//    wave_out  out  registered unsigned sample
//    wave_vld  out  wave_out comes from an enabled accumulator cycle
//    wrap      out  one-cycle pulse aligned with the post-overflow acc value
//
// Build option
//    PHASE_DITHER_EN : adds a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1,
//    seed 16'hACE1) shifted up by ACC_W-ADDR_W-16 onto the phase before it is
//    truncated to rom_addr. Latency, wrap and reset are unchanged.
// ============================================================================
module dds_phase_gen #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ACC_W-1:0]  step_val,
   input  logic [1:0]        wave_sel,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] wave_out,
   output logic              wave_vld,
   output logic              wrap
);

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  step_act_q, step_act_d;
   logic [ACC_W-1:0]  step_sh_q, step_sh_d;
   logic [1:0]        sel_sh_q, sel_sh_d;
   logic [1:0]        sel_act_q, sel_act_d;
   logic              wrap_q, wrap_d;
   logic [ACC_W:0]    sum;

   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [1:0]        sel1_q, sel1_d;
   logic              vld1_q, vld1_d;
   logic [ADDR_W-1:0] addr2_q, addr2_d;
   logic [1:0]        sel2_q, sel2_d;
   logic              vld2_q, vld2_d;
   logic [DATA_W-1:0] wave_out_q, wave_out_d;
   logic              vld3_q, vld3_d;
   logic              addr_msb;
   logic              unused_bits;

`ifdef PHASE_DITHER_EN
   localparam int DITH_SH = ACC_W - ADDR_W - 16;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [ACC_W-1:0] phase_dith;
`endif

   // Accumulator and parameter hand-over. The shadows follow the inputs every
   // cycle. On a carry the active registers take the value being captured
   // this very cycle, so a step change that coincides with the wrap is not
   // lost. While idle they take the settled shadow instead.
   always_comb begin
      sum        = {1'b0, acc_q} + {1'b0, step_act_q};
      step_sh_d  = step_val;
      sel_sh_d   = wave_sel;
      acc_d      = acc_q;
      step_act_d = step_act_q;
      sel_act_d  = sel_act_q;
      wrap_d     = 1'b0;
      if (en) begin
         acc_d  = sum[ACC_W-1:0];
         wrap_d = sum[ACC_W];
         if (sum[ACC_W]) begin
            step_act_d = step_sh_d;
            sel_act_d  = sel_sh_d;
         end
      end else begin
         step_act_d = step_sh_q;
         sel_act_d  = sel_sh_q;
      end
   end

   // Stage 1 and 2 next-state. The selector rides along with the address
   // from stage 1 so a waveform change lands exactly on the first sample of
   // the new period.
   always_comb begin
`ifdef PHASE_DITHER_EN
      lfsr_d     = en ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
      phase_dith = acc_q + (ACC_W'(lfsr_q) << DITH_SH);
      rom_addr_d = phase_dith[ACC_W-1 -: ADDR_W];
`else
      rom_addr_d = acc_q[ACC_W-1 -: ADDR_W];
`endif
      sel1_d  = sel_act_q;
      vld1_d  = en;
      addr2_d = rom_addr_q;
      sel2_d  = sel1_q;
      vld2_d  = vld1_q;
   end

   // Stage 3 waveform shaping. Triangle folds the lower address bits on the
   // MSB so it ramps up over the first half-period and down over the second.
   always_comb begin
      addr_msb   = addr2_q[ADDR_W-1];
      wave_out_d = '0;
      vld3_d     = vld2_q;
      case (sel2_q)
         2'b00:   wave_out_d = rom_data;
         2'b01:   wave_out_d = addr_msb ? '0 : '1;
         2'b10:   wave_out_d = addr_msb ? ~addr2_q[ADDR_W-2 -: DATA_W] : addr2_q[ADDR_W-2 -: DATA_W];
         default: wave_out_d = addr2_q[ADDR_W-1 -: DATA_W];
      endcase
   end

   // Low address bits below the waveform slices have no consumer by design.
`ifdef PHASE_DITHER_EN
   assign unused_bits = ^{addr2_q, phase_dith};
`else
   assign unused_bits = ^{addr2_q};
`endif

   // All state registers share one asynchronous reset; the selector resets
   // to sine and the dither LFSR to its non-zero seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         step_act_q <= '0;
         step_sh_q  <= '0;
         sel_sh_q   <= 2'b00;
         sel_act_q  <= 2'b00;
         wrap_q     <= 1'b0;
         rom_addr_q <= '0;
         sel1_q     <= 2'b00;
         vld1_q     <= 1'b0;
         addr2_q    <= '0;
         sel2_q     <= 2'b00;
         vld2_q     <= 1'b0;
         wave_out_q <= '0;
         vld3_q     <= 1'b0;
`ifdef PHASE_DITHER_EN
         lfsr_q     <= 16'hACE1;
`endif
      end else begin
         acc_q      <= acc_d;
         step_act_q <= step_act_d;
         step_sh_q  <= step_sh_d;
         sel_sh_q   <= sel_sh_d;
         sel_act_q  <= sel_act_d;
         wrap_q     <= wrap_d;
         rom_addr_q <= rom_addr_d;
         sel1_q     <= sel1_d;
         vld1_q     <= vld1_d;
         addr2_q    <= addr2_d;
         sel2_q     <= sel2_d;
         vld2_q     <= vld2_d;
         wave_out_q <= wave_out_d;
         vld3_q     <= vld3_d;
`ifdef PHASE_DITHER_EN
         lfsr_q     <= lfsr_d;
`endif
      end
   end

   assign rom_addr = rom_addr_q;
   assign wave_out = wave_out_q;
   assign wave_vld = vld3_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// ============================================================================
// tb_dds_phase_gen
// ----------------------------------------------------------------------------
// Scoreboard bench for dds_phase_gen (default parameters). The driver issues
// one accumulator cycle at a time and pushes the hand-derived sample for that
// cycle's phase index; a monitor on the falling edge pops and compares every
// time wave_vld is high. Wrap, reset state, first-sample latency and the
// idle hold behaviour are compared directly by the driver.
// A sine ROM model returns address[9:2] xor rom_xor one cycle after rom_addr.
// ============================================================================
module tb_dds_phase_gen;

   localparam logic [31:0] STEP1 = 32'h0040_0000;
   localparam logic [31:0] STEP2 = 32'h0080_0000;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] step_val;
   logic [1:0]  wave_sel;
   logic [9:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  wave_out;
   logic        wave_vld;
   logic        wrap;

   logic [7:0]  rom_xor;
   logic [7:0]  exp_q[$];
   logic        mon_en;
   logic        vld_armed;
   int          en_start;
   int          cyc;
   int          checks;
   int          errors;
   int          next_addr;

   dds_phase_gen #(.ACC_W(32), .ADDR_W(10), .DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .step_val (step_val),
      .wave_sel (wave_sel),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .wave_out (wave_out),
      .wave_vld (wave_vld),
      .wrap     (wrap)
   );

   // 100 MHz-style clock and a free-running edge counter for latency checks.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External sine ROM with one cycle of read latency.
   initial rom_data = 8'h00;
   always @(posedge clk) rom_data <= rom_addr[9:2] ^ rom_xor;

   // Runaway guard so the bench always terminates.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-derived sample for a 10-bit phase address.
   function automatic logic [7:0] expected_sample(input logic [1:0] sel, input int addr, input logic [7:0] xm);
      logic [9:0] a;
      a = addr[9:0];
      case (sel)
         2'b00:   return a[9:2] ^ xm;
         2'b01:   return a[9] ? 8'h00 : 8'hFF;
         2'b10:   return a[9] ? ~a[8:1] : a[8:1];
         default: return a[9:2];
      endcase
   endfunction

   // Phase index of enabled cycle n. With a change to STEP2 at cycle 100 the
   // new rate only starts after the first wrap at cycle 1024.
   function automatic int addr_of(input int n, input logic chg);
      if (n < 1024 || !chg) return n % 1024;
      return ((n - 1024) * 2) % 1024;
   endfunction

   function automatic logic wrap_of(input int n, input logic chg);
      if (chg) return (n == 1024) || (n > 1024 && ((n - 1024) % 512) == 0);
      return (n > 0) && ((n % 1024) == 0);
   endfunction

   // One cycle of stimulus, entered and left 1 time unit after a rising edge.
   task automatic applyStimulus(input logic en_i, input logic [31:0] step_i, input logic [1:0] sel_i,
                                input int exp_addr, input logic exp_wrap);
      en       = en_i;
      step_val = step_i;
      wave_sel = sel_i;
      checkOutput("wrap", {31'd0, wrap}, {31'd0, exp_wrap});
      if (en_i && mon_en) exp_q.push_back(expected_sample(sel_i, exp_addr, rom_xor));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en    = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
      checkOutput("rst_wave_out", {24'd0, wave_out}, 32'd0);
      checkOutput("rst_wave_vld", {31'd0, wave_vld}, 32'd0);
      checkOutput("rst_wrap",     {31'd0, wrap},     32'd0);
      exp_q.delete();
      vld_armed = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic idle(input logic [31:0] step_i, input logic [1:0] sel_i, input int ncyc);
      for (int i = 0; i < ncyc; i++) applyStimulus(1'b0, step_i, sel_i, 0, 1'b0);
   endtask

   task automatic run_phase(input logic [1:0] sel_i, input int ncyc, input logic chg, output int nxt);
      logic [31:0] stp;
      for (int n = 0; n < ncyc; n++) begin
         stp = (chg && n >= 100) ? STEP2 : STEP1;
         if (n == 0) begin
            vld_armed = 1'b1;
            en_start  = cyc;
         end
         applyStimulus(1'b1, stp, sel_i, addr_of(n, chg), wrap_of(n, chg));
      end
      nxt = addr_of(ncyc, chg);
   endtask

   // Stop accumulating, let the pipeline empty and confirm the held sample.
   task automatic drain(input logic [1:0] sel_i, input int held_addr);
      idle(STEP1, sel_i, 6);
      checkOutput("hold_wave_vld", {31'd0, wave_vld}, 32'd0);
      checkOutput("hold_wave_out", {24'd0, wave_out}, {24'd0, expected_sample(sel_i, held_addr, rom_xor)});
      checkOutput("queue_drained", exp_q.size(), 32'd0);
   endtask

   // Scoreboard monitor: every valid sample must match the next expectation.
   always @(negedge clk) begin
      if (rst_n && mon_en && wave_vld) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_sample", {24'd0, wave_out}, 32'hFFFF_FFFF);
         end else begin
            checkOutput("wave_out", {24'd0, wave_out}, {24'd0, exp_q.pop_front()});
         end
         if (vld_armed) begin
            checkOutput("first_vld_latency", cyc - en_start, 32'd3);
            vld_armed = 1'b0;
         end
      end
   end

   initial begin
      rst_n     = 1'b1;
      en        = 1'b0;
      step_val  = 32'd0;
      wave_sel  = 2'b00;
      rom_xor   = 8'h00;
      mon_en    = 1'b1;
      vld_armed = 1'b0;
      en_start  = 0;
      checks    = 0;
      errors    = 0;
      #3;
`ifdef PHASE_DITHER_EN
      mon_en = 1'b0;
      do_reset();
      idle(32'd0, 2'b00, 3);
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'b1, 32'd0, 2'b00, 0, 1'b0);
         checkOutput("dither_addr_range", {31'd0, (rom_addr <= 10'd1)}, 32'd1);
      end
      idle(32'd0, 2'b00, 3);
`else
      $display("[TB] sawtooth at step 0x%08h", STEP1);
      do_reset();
      idle(STEP1, 2'b11, 3);
      run_phase(2'b11, 1030, 1'b0, next_addr);
      drain(2'b11, next_addr);

      $display("[TB] square");
      do_reset();
      idle(STEP1, 2'b01, 3);
      run_phase(2'b01, 1030, 1'b0, next_addr);
      drain(2'b01, next_addr);

      $display("[TB] triangle");
      do_reset();
      idle(STEP1, 2'b10, 3);
      run_phase(2'b10, 1030, 1'b0, next_addr);
      drain(2'b10, next_addr);

      $display("[TB] step change at cycle 100");
      do_reset();
      idle(STEP1, 2'b11, 3);
      run_phase(2'b11, 1600, 1'b1, next_addr);
      drain(2'b11, next_addr);

      $display("[TB] sine via ROM model");
      rom_xor = 8'h00;
      do_reset();
      idle(STEP1, 2'b00, 3);
      run_phase(2'b00, 200, 1'b0, next_addr);
      drain(2'b00, next_addr);
      rom_xor = 8'hA5;
      do_reset();
      idle(STEP1, 2'b00, 3);
      run_phase(2'b00, 200, 1'b0, next_addr);
      drain(2'b00, next_addr);
      rom_xor = 8'h00;

      $display("[TB] reset mid-period then restart");
      do_reset();
      idle(STEP1, 2'b11, 3);
      run_phase(2'b11, 300, 1'b0, next_addr);
      do_reset();
      idle(STEP1, 2'b11, 3);
      run_phase(2'b11, 1030, 1'b0, next_addr);
      drain(2'b11, next_addr);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dds_phase_gen.md
DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32, phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 10, waveform address width taken from accumulator MSBs.
REQ-003 SHALL have parameter DATA_W, default 8, sample width.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  accumulate enable; low freezes the accumulator.
REQ-007 SHALL have port step_val  input  ACC_W  phase increment from frequency control stage; may change on any cycle.
REQ-008 SHALL have port wave_sel  input  2  waveform: 00 sine, 01 square, 10 triangle, 11 sawtooth.
REQ-009 SHALL have port rom_addr  output  ADDR_W  registered address to external sine ROM with 1-cycle read latency.
REQ-010 SHALL have port rom_data  input  DATA_W  unsigned offset-binary sine sample, valid 1 cycle after rom_addr.
REQ-011 SHALL have port wave_out  output  DATA_W  registered unsigned sample.
REQ-012 SHALL have port wave_vld  output  1  high when wave_out carries a sample from an enabled accumulator cycle.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when the accumulator overflows.

Function
REQ-014 SHALL, when en=1, update acc <= acc + step_act (mod 2^ACC_W) each cycle; when en=0, hold acc.
REQ-015 SHALL capture step_val and wave_sel into shadow registers every cycle.
REQ-016 SHALL load step_act and sel_act from shadow only on a cycle where the addition carries out (wrap) or en=0, so that frequency and waveform changes while running take effect at a period boundary.
REQ-017 SHALL, when a wrap and a new step_val coincide, use the shadow value captured on that cycle.
REQ-018 SHALL assert wrap one cycle after the overflowing addition, aligned with the new acc value.
REQ-019 SHALL register rom_addr = acc[ACC_W-1:ACC_W-ADDR_W] (stage 1).
REQ-020 SHALL delay the address and sel_act one cycle to align with rom_data (stage 2).
REQ-021 SHALL compute wave_out in stage 3: sine = rom_data; square = addr MSB ? 0 : all-ones; triangle = addr MSB ? ~addr[ADDR_W-2 -: DATA_W] : addr[ADDR_W-2 -: DATA_W]; sawtooth = addr[ADDR_W-1 -: DATA_W].
REQ-022 SHALL produce wave_out exactly 3 cycles after the acc value it derives from; wave_vld is en delayed through the same 3 stages.
REQ-023 SHALL, with step_act=0 and en=1, produce a constant wave_out with wave_vld=1.
REQ-024 SHALL keep outputs from the last address stable while en=0, with wave_vld=0 after the pipeline drains.

Reset
REQ-025 SHALL asynchronously clear acc, step_act, shadows, sel_act (sine), rom_addr, all pipeline stages, wave_out, wave_vld and wrap to 0 on rst_n low.
REQ-026 SHALL, on reset asserted mid-operation, discard in-flight samples; first wave_vld after release occurs 3 cycles after the first en=1 cycle.

Configuration
REQ-027 SHALL support macro PHASE_DITHER_EN: when defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every en cycle) is added, left-shifted by ACC_W-ADDR_W-16, to acc before truncation to rom_addr; when undefined, no LFSR exists and rom_addr is pure truncation.
REQ-028 SHALL keep latency, wrap timing and reset behaviour identical with and without PHASE_DITHER_EN.

Verification (dither off unless stated)
REQ-029 SHALL cover: reset, en=1, step_val=32'h0040_0000, wave_sel=11 -> wave_out 0x00,0x00,0x00,0x00,0x01,... one step per 4 cycles, first wave_vld 3 cycles after first en cycle, wrap every 1024 cycles.
REQ-030 SHALL cover: step_val=32'h0040_0000, wave_sel=01 -> wave_out 0xFF for 512 cycles then 0x00 for 512 cycles.
REQ-031 SHALL cover: running at step 32'h0040_0000, change to 32'h0080_0000 at cycle 100 -> rate unchanged until next wrap (cycle 1024 from start), then period 512 cycles.
REQ-032 SHALL cover: wave_sel 00 with ROM model returning address[9:2] -> wave_out equals model output at 3-cycle latency.
REQ-033 SHALL cover: rst_n pulsed low mid-period -> all outputs 0 immediately; restart reproduces the REQ-029 sequence.
REQ-034 SHALL cover, with PHASE_DITHER_EN: step_val=0 -> rom_addr varies within 1 LSB of 0 and wrap never asserts.
